// File: rtl/hex_keypad_pkg.sv
// Shared types and constants for the hex keypad entry block.
package hex_keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [3:0] ROW_INIT   = 4'b1110;
    localparam int         KEY_CODE_W = 4;

    // Position of the lowest low bit; callers only use it when some bit is low.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/hex_keypad_entry_sync2.sv
// Two-flop synchronizer; resets to all-ones so idle (pulled-up) columns read as released.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner: row scan, debounce, and a left-shifting 8-digit entry register.
module hex_keypad_entry
    import hex_keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 15,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  col,
    input  logic        entry_clr,
    output logic [3:0]  row,
    output logic [31:0] value,
    output logic        key_valid,
    output logic [KEY_CODE_W-1:0] key_code
);

    logic [3:0] col_s;

    sync2 #(.WIDTH(4)) u_col_sync (
        .clk  (clk),
        .clr  (clr),
        .din  (col),
        .dout (col_s)
    );

    kp_state_e               state_q, state_d;
    logic [SCAN_DIV_BITS-1:0] div_q, div_d;
    logic [3:0]              row_q, row_d;
    logic [1:0]              row_idx_q, row_idx_d;
    logic [1:0]              col_idx_q, col_idx_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             value_q, value_d;
    logic                    key_valid_q, key_valid_d;
    logic [KEY_CODE_W-1:0]   key_code_q, key_code_d;

    logic                    tick;
    logic [3:0]              cnt_inc;
    logic [3:0]              row_next;
    logic [KEY_CODE_W-1:0]   code;

    assign tick     = &div_q;
    assign cnt_inc  = cnt_q + 4'd1;
    assign row_next = {row_q[2:0], row_q[3]};
    assign code     = {row_idx_q, col_idx_q};

    always_comb begin
        state_d     = state_q;
        div_d       = div_q + {{(SCAN_DIV_BITS-1){1'b0}}, 1'b1};
        row_d       = row_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        cnt_d       = cnt_q;
        value_d     = value_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;

        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (col_s != 4'hF) begin
                        row_idx_d = low_index(row_q);
                        col_idx_d = low_index(col_s);
                        cnt_d     = 4'd1;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        row_d = row_next;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (col_s[col_idx_q]) begin
                        cnt_d   = 4'd0;
                        row_d   = row_next;
                        state_d = ST_SCAN;
                    end else if (low_index(col_s) == col_idx_q) begin
                        // A lower column joining in just stalls the count.
                        cnt_d = cnt_inc;
                        if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
                            state_d = ST_PRESSED;
                        end
                    end
                end
            end
            ST_PRESSED: begin
                key_valid_d = 1'b1;
                key_code_d  = code;
                value_d     = {value_q[31-KEY_CODE_W:0], code};
                cnt_d       = 4'd0;
                state_d     = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (tick) begin
                    if (col_s == 4'hF) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
                            cnt_d   = 4'd0;
                            row_d   = row_next;
                            state_d = ST_SCAN;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase

        // Clear beats a simultaneous shift; the key is still reported.
        if (entry_clr) begin
            value_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_SCAN;
            div_q       <= '0;
            row_q       <= ROW_INIT;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            cnt_q       <= 4'd0;
            value_q     <= 32'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            row_q       <= row_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign row       = row_q;
    assign value     = value_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Scoreboard bench for hex_keypad_entry: a keypad model drives col from row; key pulses are checked against a queue.
module tb_hex_keypad_entry;

    localparam int SDB = 2;
    localparam int DS  = 3;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        entry_clr = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [31:0] value;
    logic        key_valid;
    logic [3:0]  key_code;

    logic        key_down = 1'b0;
    logic [1:0]  key_r = 2'd0;
    logic [1:0]  key_c = 2'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int pc       = 0;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] value;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_value = 32'd0;

    hex_keypad_entry #(
        .SCAN_DIV_BITS  (SDB),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .col       (col),
        .entry_clr (entry_clr),
        .row       (row),
        .value     (value),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    always #5 clk = ~clk;

    // Matrix model: the held key pulls its column low only while its row is driven.
    assign col = (key_down && row[key_r] == 1'b0) ? ~(4'b0001 << key_c) : 4'hF;

    // Cycle count since reset; state updates on tick happen at edges where pc % 4 == 0.
    always @(posedge clk or posedge clr) begin
        if (clr) pc <= 0;
        else     pc <= pc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!clr && key_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_key_valid: got pulse with key_code %h value %h, required none",
                         key_code, value);
            end else begin
                e = exp_q.pop_front();
                $display("key_valid: key_code %h value %h (expected %h / %h)", key_code, value, e.code, e.value);
                check("key_code", {28'd0, key_code}, {28'd0, e.code});
                check("value", value, e.value);
            end
        end
    end

    task automatic wait_tick();
        do @(negedge clk); while (pc % 4 != 0);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic wait_row(input logic [3:0] target);
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev  = row;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (row == target && prev != target) found = 1'b1;
            prev = row;
        end
        check("wait_row_timeout", {31'd0, found}, 32'd1);
    endtask

    task automatic push_expect(input logic [3:0] code, input bit cleared);
        exp_value = cleared ? 32'd0 : {exp_value[27:0], code};
        exp_q.push_back(exp_t'{code: code, value: exp_value});
    endtask

    task automatic key_stroke(input logic [1:0] r, input logic [1:0] c, input int hold, input int rel);
        push_expect({r, c}, 1'b0);
        key_r    = r;
        key_c    = c;
        key_down = 1'b1;
        wait_ticks(hold);
        key_down = 1'b0;
        wait_ticks(rel);
    endtask

    initial begin : timeout
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] prev;
        logic [3:0] k4;
        int changes;
        int last;

        repeat (3) @(negedge clk);
        check("rst_row", {28'd0, row}, 32'h0000_000E);
        check("rst_value", value, 32'd0);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_code", {28'd0, key_code}, 32'd0);
        clr = 1'b0;

        // 1: idle scan
        prev = row;
        changes = 0;
        last = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (row !== prev) begin
                changes++;
                check("t1_row_seq", {28'd0, row}, {28'd0, prev[2:0], prev[3]});
                if (changes > 1) check("t1_row_period", i - last, 4);
                last = i;
                prev = row;
            end
        end
        check("t1_row_steps", changes, 16);
        check("t1_value", value, 32'd0);

        // 2: single key at row 1, column 2, held for 20 ticks
        key_stroke(2'd1, 2'd2, 20, 10);
        check("t2_value", value, 32'h0000_0006);
        check("t2_key_code", {28'd0, key_code}, 32'd6);
        check("t2_pulses", exp_q.size(), 0);

        // 3: keys 1..9
        for (int k = 1; k <= 9; k++) begin
            k4 = 4'(k);
            key_stroke(k4[3:2], k4[1:0], 14, 8);
        end
        check("t3_value", value, 32'h2345_6789);
        check("t3_pulses", exp_q.size(), 0);

        // 4: one-tick bounce on row 0, column 0
        wait_row(4'b1110);
        key_r = 2'd0;
        key_c = 2'd0;
        key_down = 1'b1;
        wait_tick();
        check("t4_row_held", {28'd0, row}, 32'h0000_000E);
        key_down = 1'b0;
        wait_tick();
        check("t4_row_next", {28'd0, row}, 32'h0000_000D);
        wait_ticks(6);
        check("t4_value", value, 32'h2345_6789);

        // 5: long hold, two-tick toggle, then release
        wait_row(4'b1011);
        push_expect(4'hA, 1'b0);
        key_r = 2'd2;
        key_c = 2'd2;
        key_down = 1'b1;
        wait_ticks(100);
        key_down = 1'b0;
        wait_tick();
        key_down = 1'b1;
        wait_tick();
        key_down = 1'b0;
        wait_tick();
        check("t5_row_hold1", {28'd0, row}, 32'h0000_000B);
        wait_tick();
        check("t5_row_hold2", {28'd0, row}, 32'h0000_000B);
        wait_tick();
        check("t5_row_resume", {28'd0, row}, 32'h0000_0007);
        check("t5_pulses", exp_q.size(), 0);
        check("t5_value", value, 32'h3456_789A);

        // 6a: entry_clr coinciding with PRESSED
        wait_row(4'b1101);
        push_expect(4'h7, 1'b1);
        key_r = 2'd1;
        key_c = 2'd3;
        key_down = 1'b1;
        wait_ticks(DS);
        entry_clr = 1'b1;
        @(negedge clk);
        entry_clr = 1'b0;
        check("t6a_key_valid", {31'd0, key_valid}, 32'd1);
        key_down = 1'b0;
        wait_ticks(8);
        check("t6a_value", value, 32'd0);
        check("t6a_pulses", exp_q.size(), 0);

        // 6b: clr in the middle of debounce
        key_stroke(2'd3, 2'd3, 14, 8);
        check("t6b_pre_value", value, 32'h0000_000F);
        wait_row(4'b1101);
        key_r = 2'd1;
        key_c = 2'd0;
        key_down = 1'b1;
        wait_ticks(2);
        clr = 1'b1;
        #1;
        check("t6b_row", {28'd0, row}, 32'h0000_000E);
        check("t6b_value", value, 32'd0);
        check("t6b_key_valid", {31'd0, key_valid}, 32'd0);
        check("t6b_key_code", {28'd0, key_code}, 32'd0);
        key_down = 1'b0;
        exp_value = 32'd0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        wait_ticks(10);
        check("t6b_pulses", exp_q.size(), 0);
        check("t6b_value_after", value, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
